debug_trace_buffer: RTL and testbench
=====================================

# debug_trace_buffer

Downstream capture stage for the SNN debug multiplexer. It samples the 8-bit debug word once per enabled network timestep into a circular pre-trigger buffer. On a trigger it records a fixed number of post-trigger samples, freezes, and then streams the window out oldest-first over a valid/ready byte interface. This lets the chip-level SPI/pin logic read membrane-potential or spike traces at its own pace.

## Interface
Parameters:
- DATA_W, 8, width of one debug sample (matches the debug mux output)
- DEPTH, 16, ring entries; power of two, at least 4
- POST, 8, post-trigger samples recorded, counting the trigger sample; 1 ≤ POST ≤ DEPTH
- ADDR_W, $clog2(DEPTH), pointer width (derived)

Ports:
- clk  in  1  single clock
- rst  in  1  synchronous, active-high reset
- en  in  1  sample strobe, one pulse per SNN timestep
- debug_in  in  DATA_W  selected debug word
- arm  in  1  start pre-trigger capture
- trigger  in  1  capture event
- dout  out  DATA_W  streamed sample
- dout_valid  out  1  dout holds a valid sample
- dout_last  out  1  dout is the final sample of the window
- dout_ready  in  1  consumer accepts dout
- state  out  2  current FSM state
- done  out  1  one-cycle pulse after the last beat is accepted

## Operation
- FSM states: IDLE=0, ARMED=1, POSTCAP=2, DUMP=3.
- IDLE:
  - `arm` → ARMED on the next edge.
  - `wr_ptr` and `fill` clear on the arm edge.
  - `trigger` and `en` are ignored.
- ARMED:
  - Each `en` writes `debug_in` to `mem[wr_ptr]`, increments `wr_ptr` (wraps modulo DEPTH), and increments `fill`, saturating at DEPTH.
  - `trigger` → POSTCAP with `post_cnt` = 0.
  - If `en` is high in the trigger cycle, that sample is written and counts as post sample 1.
- POSTCAP:
  - Each `en` writes as in ARMED and increments `post_cnt`.
  - When `post_cnt` reaches POST → DUMP. The transition fires on the edge that writes the POST-th sample.
  - Further `trigger` is ignored.
- Pre-trigger history: overwrite is normal behaviour. Window length is `fill` at DUMP entry: min(DEPTH, samples written since arm).
- DUMP:
  - `rd_ptr` = `wr_ptr` − `fill` (mod DEPTH) and `rem` = `fill`, both latched on entry.
  - Presents `mem[rd_ptr]` on `dout`. Each accepted beat (`dout_valid && dout_ready` at an edge) advances `rd_ptr` and decrements `rem`.
  - `dout_last` = (`rem` == 1) while valid.
  - After the last beat: → IDLE and `done` pulses for one cycle.
  - `en`, `arm` and `trigger` are ignored in DUMP.
- Calling `arm` while in ARMED or POSTCAP restarts capture: pointers clear, state goes to ARMED.
- `arm` and `trigger` together in IDLE → ARMED only; the trigger is lost.

## Timing
- Reset values: `state`=IDLE, `dout`=0, `dout_valid`=0, `dout_last`=0, `done`=0, all pointers and counters 0. Memory contents are not reset.
- A sample written at edge N is readable from N+1.
- `dout_valid` rises the cycle after DUMP entry; all outputs are registered.
- With `dout_ready` held high, throughput is one beat per cycle with no bubbles.
- Under backpressure, `dout`, `dout_valid` and `dout_last` hold stable until accepted.
- `dout_valid` drops the cycle after the last beat; `done` is high in that same cycle.
- Reset asserted mid-capture or mid-dump: all outputs take their reset values on that edge, and the in-flight window is discarded.

## Structure
- Shared package `snn_debug_pkg`: DATA_W default and the state enum (IDLE/ARMED/POSTCAP/DUMP).
- Sub-module `debug_trace_ram`: DEPTH×DATA_W register array with one write port and a combinational read port.
- The FSM, pointers and output register live in the top module.

## Test plan
- Reset: assert `rst` for 2 cycles → all outputs 0, `state`=0. Then drive `en` and `trigger` in IDLE → no state change.
- Wrap (DEPTH=16, POST=8): arm, then 20 `en` with data 0..19, then `trigger` with `en` on data 20, then 7 `en` on 21..27. Expect 16 beats 12..27, `dout_last` on 27, `done` one cycle after.
- Short pre-fill: arm, 3 samples A0..A2, trigger + 8 post samples B0..B7. Expect 11 beats, A0 first and B7 last.
- Backpressure: toggle `dout_ready` with a 1-on/2-off pattern during the wrap case. The sequence is unchanged, with no duplicates or drops, and `dout` is stable while not ready.
- Same-cycle events: `arm`+`trigger` in IDLE → ARMED with no capture. Re-arm in POSTCAP → window restarts and only new samples are dumped.
- Reset mid-dump after 5 beats → `dout_valid`=0 and IDLE next cycle. A fresh arm/trigger cycle then dumps correctly.

Source files
------------

// File: rtl/snn_debug_pkg.sv
// rtl/snn_debug_pkg.sv - shared types and defaults for the SNN debug capture path
// Purpose: default debug sample width and the trace buffer state encoding.
// Ports: none (package).
package snn_debug_pkg;

  localparam int DEBUG_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_POSTCAP = 2'd2,
    ST_DUMP    = 2'd3
  } trace_state_e;

endpackage

// File: rtl/debug_trace_ram.sv
// rtl/debug_trace_ram.sv - DEPTH x DATA_W sample store, one write port, async read
// Purpose: holds the circular trace window; contents are intentionally not reset.
// Ports:
//   clk   - clock
//   we    - write enable
//   waddr - write address
//   wdata - write data
//   raddr - read address
//   rdata - combinational read data at raddr
module debug_trace_ram
  import snn_debug_pkg::*;
#(
  parameter int DATA_W = DEBUG_DATA_W,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/debug_trace_buffer.sv
// rtl/debug_trace_buffer.sv - pre/post-trigger trace capture with oldest-first byte dump
// Purpose: samples debug_in on each en into a ring, records POST samples after a
// trigger, then streams the captured window out over a valid/ready interface.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   en, debug_in      - sample strobe and sample data
//   arm, trigger      - start (or restart) capture, capture event
//   dout, dout_valid, dout_last, dout_ready - registered output stream
//   state             - current FSM state
//   done              - one-cycle pulse after the final beat is accepted
module debug_trace_buffer
  import snn_debug_pkg::*;
#(
  parameter int DATA_W = DEBUG_DATA_W,
  parameter int DEPTH  = 16,
  parameter int POST   = 8,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] debug_in,
  input  logic              arm,
  input  logic              trigger,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              dout_last,
  input  logic              dout_ready,
  output logic [1:0]        state,
  output logic              done
);

  // Counters need one extra bit so they can hold DEPTH itself.
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] POST_C  = CNT_W'(POST);

  trace_state_e      state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  fill_q, fill_d;
  logic [CNT_W-1:0]  post_cnt_q, post_cnt_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              dout_valid_q, dout_valid_d;
  logic              dout_last_q, dout_last_d;
  logic              done_q, done_d;

  logic              mem_we;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              accept;

  assign accept = dout_valid_q && dout_ready;

  debug_trace_ram #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk  (clk),
    .we   (mem_we),
    .waddr(wr_ptr_q),
    .wdata(debug_in),
    .raddr(rd_addr),
    .rdata(rd_data)
  );

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    fill_d       = fill_q;
    post_cnt_d   = post_cnt_q;
    rem_d        = rem_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    dout_last_d  = dout_last_q;
    done_d       = 1'b0;
    mem_we       = 1'b0;
    // Look one entry ahead on acceptance so the next beat loads without a bubble.
    rd_addr      = accept ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;

    unique case (state_q)
      ST_IDLE: begin
        if (arm) begin
          state_d    = ST_ARMED;
          wr_ptr_d   = '0;
          fill_d     = '0;
          post_cnt_d = '0;
        end
      end

      ST_ARMED, ST_POSTCAP: begin
        if (arm) begin
          state_d    = ST_ARMED;
          wr_ptr_d   = '0;
          fill_d     = '0;
          post_cnt_d = '0;
        end else begin
          if (en) begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
            if (fill_q != DEPTH_C) begin
              fill_d = fill_q + CNT_W'(1);
            end
          end
          if (state_q == ST_ARMED) begin
            if (trigger) begin
              state_d    = ST_POSTCAP;
              post_cnt_d = en ? CNT_W'(1) : '0;
            end
          end else if (en) begin
            post_cnt_d = post_cnt_q + CNT_W'(1);
          end
          // Covers POST==1 with en in the trigger cycle: straight to DUMP.
          if (state_d == ST_POSTCAP && post_cnt_d == POST_C) begin
            state_d  = ST_DUMP;
            rd_ptr_d = wr_ptr_d - fill_d[ADDR_W-1:0];
            rem_d    = fill_d;
          end
        end
      end

      ST_DUMP: begin
        if (!dout_valid_q) begin
          dout_d       = rd_data;
          dout_valid_d = 1'b1;
          dout_last_d  = (rem_q == CNT_W'(1));
        end else if (dout_ready) begin
          rd_ptr_d = rd_ptr_q + ADDR_W'(1);
          rem_d    = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) begin
            dout_valid_d = 1'b0;
            dout_last_d  = 1'b0;
            done_d       = 1'b1;
            state_d      = ST_IDLE;
          end else begin
            dout_d      = rd_data;
            dout_last_d = (rem_q == CNT_W'(2));
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fill_q       <= '0;
      post_cnt_q   <= '0;
      rem_q        <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      dout_last_q  <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fill_q       <= fill_d;
      post_cnt_q   <= post_cnt_d;
      rem_q        <= rem_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      dout_last_q  <= dout_last_d;
      done_q       <= done_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign dout_last  = dout_last_q;
  assign state      = state_q;
  assign done       = done_q;

endmodule

// File: tb/tb_debug_trace_buffer.sv
// tb/tb_debug_trace_buffer.sv - self-checking bench for debug_trace_buffer
module tb_debug_trace_buffer;

  localparam int DEPTH = 16;
  localparam int POST  = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [7:0] debug_in = 8'h00;
  logic       arm = 1'b0;
  logic       trigger = 1'b0;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_last;
  logic       dout_ready = 1'b1;
  logic [1:0] state;
  logic       done;

  int checks = 0;
  int errors = 0;

  // Reference: every sample written since the last arm, oldest first.
  logic [7:0] hist[$];
  logic [7:0] got_data[$];
  bit         got_last[$];
  int         stable_bad;
  int         done_cyc;
  int         first_valid_cyc;

  debug_trace_buffer #(.DATA_W(8), .DEPTH(DEPTH), .POST(POST)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .debug_in  (debug_in),
    .arm       (arm),
    .trigger   (trigger),
    .dout      (dout),
    .dout_valid(dout_valid),
    .dout_last (dout_last),
    .dout_ready(dout_ready),
    .state     (state),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic step(input bit e, input logic [7:0] d, input bit a, input bit t);
    @(negedge clk);
    en = e; debug_in = d; arm = a; trigger = t;
  endtask

  // Arm (optionally), n_pre samples, trigger, then post samples until POST are counted.
  task automatic capture(input bit do_arm, input int n_pre, input bit trig_en,
                         input bit gaps, input bit seq);
    int posts;
    logic [7:0] v;
    v = 8'd0;
    if (do_arm) begin
      step(0, 8'h00, 1, 0);
      hist.delete();
    end
    for (int i = 0; i < n_pre; i++) begin
      if (gaps && ($urandom % 3 == 0)) step(0, 8'($urandom), 0, 0);
      if (!seq) v = 8'($urandom);
      step(1, v, 0, 0);
      hist.push_back(v);
      v = v + 8'd1;
    end
    if (!seq) v = 8'($urandom);
    step(trig_en, v, 0, 1);
    posts = 0;
    if (trig_en) begin
      hist.push_back(v);
      v = v + 8'd1;
      posts = 1;
    end
    while (posts < POST) begin
      if (gaps && ($urandom % 3 == 0)) step(0, 8'($urandom), 0, $urandom % 2 == 0);
      if (!seq) v = 8'($urandom);
      step(1, v, 0, 0);
      hist.push_back(v);
      v = v + 8'd1;
      posts++;
    end
  endtask

  // Consume the dump. mode 0: always ready, 1: ready 1-on/2-off, 2: random ready
  // with random en/arm/trigger noise that the DUMP state must ignore.
  task automatic drain(input int mode);
    bit r;
    bit hold;
    logic [7:0] hd;
    logic hl;
    got_data.delete(); got_last.delete();
    stable_bad = 0; done_cyc = -1; first_valid_cyc = -1; hold = 0;
    hd = 8'h00; hl = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      if (hold && (dout_valid !== 1'b1 || dout !== hd || dout_last !== hl)) stable_bad++;
      if (dout_valid === 1'b1 && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (done === 1'b1) begin
        done_cyc = cyc;
        en = 0; arm = 0; trigger = 0;
        break;
      end
      case (mode)
        0: r = 1'b1;
        1: r = (cyc % 3 == 0);
        default: r = 1'($urandom);
      endcase
      if (mode == 2) begin
        en = 1'($urandom); arm = 1'($urandom); trigger = 1'($urandom); debug_in = 8'($urandom);
      end else begin
        en = 0; arm = 0; trigger = 0;
      end
      dout_ready = r;
      if (dout_valid === 1'b1 && r) begin
        got_data.push_back(dout);
        got_last.push_back(dout_last);
      end
      hold = (dout_valid === 1'b1) && !r;
      hd = dout; hl = dout_last;
    end
    dout_ready = 1'b1;
  endtask

  // Number of differences between the received stream and the reference window.
  function automatic int window_errs();
    int k;
    int e;
    int base;
    e = 0;
    k = (hist.size() < DEPTH) ? hist.size() : DEPTH;
    base = hist.size() - k;
    if (got_data.size() != k) e++;
    for (int i = 0; i < k && i < got_data.size(); i++) begin
      if (got_data[i] !== hist[base + i]) e++;
      if (got_last[i] != (i == k - 1)) e++;
    end
    return e;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({dout, dout_valid, dout_last, done} !== 11'd0)
      begin errors++; $display("FAIL reset_outputs got=%h want=0", {dout, dout_valid, dout_last, done}); end
    checks++;
    if (state !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d want=0", state); end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) step(1, 8'($urandom), 0, 1);
    step(0, 8'h00, 0, 0);
    checks++;
    if (state !== 2'd0) begin errors++; $display("FAIL idle_ignore_state got=%0d want=0", state); end
    checks++;
    if (dout_valid !== 1'b0) begin errors++; $display("FAIL idle_ignore_valid got=%b want=0", dout_valid); end
  endtask

  task automatic test_wrap();
    capture(1, 20, 1, 0, 1);
    drain(0);
    checks++;
    if (window_errs() != 0)
      begin errors++; $display("FAIL wrap_window bad=%0d got_len=%0d want_len=16", window_errs(), got_data.size()); end
    checks++;
    if (got_data.size() > 0 && got_data[0] !== 8'd12)
      begin errors++; $display("FAIL wrap_first got=%0d want=12", got_data[0]); end
    checks++;
    if (first_valid_cyc != 1)
      begin errors++; $display("FAIL wrap_valid_latency got=%0d want=1", first_valid_cyc); end
    checks++;
    if (done_cyc != 17) begin errors++; $display("FAIL wrap_done_cycle got=%0d want=17", done_cyc); end
    checks++;
    if (dout_valid !== 1'b0) begin errors++; $display("FAIL wrap_valid_at_done got=%b want=0", dout_valid); end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || state !== 2'd0)
      begin errors++; $display("FAIL wrap_done_pulse got done=%b state=%0d want 0/0", done, state); end
  endtask

  task automatic test_short_prefill();
    capture(1, 3, 0, 0, 0);
    drain(0);
    checks++;
    if (window_errs() != 0)
      begin errors++; $display("FAIL short_window bad=%0d got_len=%0d want_len=11", window_errs(), got_data.size()); end
    checks++;
    if (done_cyc != 12) begin errors++; $display("FAIL short_done_cycle got=%0d want=12", done_cyc); end
  endtask

  task automatic test_backpressure();
    capture(1, 20, 1, 0, 1);
    drain(1);
    checks++;
    if (window_errs() != 0)
      begin errors++; $display("FAIL bp_window bad=%0d got_len=%0d want_len=16", window_errs(), got_data.size()); end
    checks++;
    if (stable_bad != 0) begin errors++; $display("FAIL bp_stable got=%0d want=0", stable_bad); end
    checks++;
    if (done_cyc < 0) begin errors++; $display("FAIL bp_timeout got=%0d want>=0", done_cyc); end
  endtask

  task automatic test_same_cycle();
    step(0, 8'h00, 1, 1);
    hist.delete();
    step(0, 8'h00, 0, 0);
    checks++;
    if (state !== 2'd1) begin errors++; $display("FAIL arm_trig_state got=%0d want=1", state); end
    for (int i = 0; i < 3; i++) step(1, 8'($urandom), 0, 0);
    step(1, 8'($urandom), 0, 1);
    step(1, 8'($urandom), 0, 0);
    step(1, 8'($urandom), 0, 0);
    step(0, 8'h00, 0, 0);
    checks++;
    if (state !== 2'd2) begin errors++; $display("FAIL postcap_state got=%0d want=2", state); end
    step(0, 8'h00, 1, 0);
    hist.delete();
    step(0, 8'h00, 0, 0);
    checks++;
    if (state !== 2'd1) begin errors++; $display("FAIL rearm_state got=%0d want=1", state); end
    capture(0, 4, 1, 0, 0);
    drain(0);
    checks++;
    if (window_errs() != 0)
      begin errors++; $display("FAIL rearm_window bad=%0d got_len=%0d want_len=12", window_errs(), got_data.size()); end
  endtask

  task automatic test_reset_mid_dump();
    capture(1, 20, 1, 0, 1);
    @(negedge clk);
    en = 0; arm = 0; trigger = 0; dout_ready = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (dout_valid !== 1'b0 || state !== 2'd0 || done !== 1'b0 || dout !== 8'd0)
      begin errors++; $display("FAIL mid_dump_reset got valid=%b state=%0d done=%b dout=%0d want 0", dout_valid, state, done, dout); end
    capture(1, 9, 1, 0, 0);
    drain(0);
    checks++;
    if (window_errs() != 0)
      begin errors++; $display("FAIL after_reset_window bad=%0d got_len=%0d", window_errs(), got_data.size()); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      capture(1, $urandom_range(0, 30), 1'($urandom), 1, 0);
      drain(2);
      checks++;
      if (window_errs() != 0)
        begin errors++; $display("FAIL rand_window it=%0d bad=%0d got_len=%0d hist=%0d", it, window_errs(), got_data.size(), hist.size()); end
      checks++;
      if (stable_bad != 0) begin errors++; $display("FAIL rand_stable it=%0d got=%0d want=0", it, stable_bad); end
      checks++;
      if (done_cyc < 0 || dout_valid !== 1'b0)
        begin errors++; $display("FAIL rand_done it=%0d got cyc=%0d valid=%b", it, done_cyc, dout_valid); end
    end
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_short_prefill();
    test_backpressure();
    test_same_cycle();
    test_reset_mid_dump();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
